// File: rtl/nic_clk_pkg.sv
// Shared types and constants for the NIC MMCM clock manager: FSM encodings,
// speed codes, and the CLKOUT0 DRP retune table.
package nic_clk_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_DRP,
        ST_LOCK_W,
        ST_RUN,
        ST_FAIL
    } mgr_state_t;

    typedef enum logic [2:0] {
        RMW_IDLE,
        RMW_RD,
        RMW_RD_W,
        RMW_WR,
        RMW_WR_W
    } rmw_state_t;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    localparam logic [6:0] DRP_ADDR_CLKREG1 = 7'h08;
    localparam logic [6:0] DRP_ADDR_CLKREG2 = 7'h09;

    localparam logic [15:0] KEEP_CLKREG1 = 16'hF000;
    localparam logic [15:0] KEEP_CLKREG2 = 16'hFC00;

    // VCO 1000 MHz: /8 gives 125 MHz, /40 gives 25 MHz
    localparam logic [15:0] VAL_DIV8    = 16'h0104;
    localparam logic [15:0] VAL_DIV40   = 16'h0514;
    localparam logic [15:0] VAL_CLKREG2 = 16'h0000;

    localparam int TABLE_ENTRIES = 2;
    localparam int IDX_W         = $clog2(TABLE_ENTRIES);

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] keep;
        logic [15:0] val;
    } drp_entry_t;

    // The reserved code 2'b11 is folded onto 1000M
    function automatic logic [1:0] norm_speed(input logic [1:0] speed);
        logic [1:0] s;
        case (speed)
            SPEED_100M: s = SPEED_100M;
            SPEED_10M:  s = SPEED_10M;
            default:    s = SPEED_1000M;
        endcase
        return s;
    endfunction

    // 10M and 100M share /40; 2.5 MHz comes from the MAC clock enable
    function automatic drp_entry_t table_entry(input logic [IDX_W-1:0] idx,
                                               input logic [1:0] speed);
        drp_entry_t e;
        if (idx == '0) begin
            e.addr = DRP_ADDR_CLKREG1;
            e.keep = KEEP_CLKREG1;
            e.val  = (speed == SPEED_1000M) ? VAL_DIV8 : VAL_DIV40;
        end else begin
            e.addr = DRP_ADDR_CLKREG2;
            e.keep = KEEP_CLKREG2;
            e.val  = VAL_CLKREG2;
        end
        return e;
    endfunction

endpackage

// File: rtl/nic_clk_drp_rmw.sv
// Single DRP read-modify-write engine: reads addr, writes (data & keep) | val,
// pulses done when the write completes. Only one transaction is ever in flight.
module nic_clk_drp_rmw
    import nic_clk_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        start,
    input  logic [6:0]  addr,
    input  logic [15:0] keep,
    input  logic [15:0] val,
    output logic        done,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
);

    rmw_state_t  state_reg, state_next;
    logic [6:0]  addr_reg, addr_next;
    logic [15:0] keep_reg, keep_next;
    logic [15:0] val_reg, val_next;
    logic [15:0] di_reg, di_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= RMW_IDLE;
            addr_reg  <= '0;
            keep_reg  <= '0;
            val_reg   <= '0;
            di_reg    <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            keep_reg  <= keep_next;
            val_reg   <= val_next;
            di_reg    <= di_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        keep_next  = keep_reg;
        val_next   = val_reg;
        di_next    = di_reg;
        done       = 1'b0;
        case (state_reg)
            RMW_IDLE: begin
                if (start) begin
                    addr_next  = addr;
                    keep_next  = keep;
                    val_next   = val;
                    state_next = RMW_RD;
                end
            end
            RMW_RD:   state_next = RMW_RD_W;
            RMW_RD_W: begin
                // drdy is only meaningful here and in WR_W; elsewhere it is dropped
                if (drp_drdy) begin
                    di_next    = (drp_do & keep_reg) | val_reg;
                    state_next = RMW_WR;
                end
            end
            RMW_WR:   state_next = RMW_WR_W;
            RMW_WR_W: begin
                if (drp_drdy) begin
                    done       = 1'b1;
                    state_next = RMW_IDLE;
                end
            end
            default:  state_next = RMW_IDLE;
        endcase
    end

    assign drp_den   = (state_reg == RMW_RD) || (state_reg == RMW_WR);
    assign drp_dwe   = (state_reg == RMW_WR);
    assign drp_daddr = addr_reg;
    assign drp_di    = di_reg;

endmodule

// File: rtl/nic_clk_mgr.sv
// NIC MMCM sequencer: holds the MMCM in reset, retunes CLKOUT0 over DRP, then waits
// for lock with timeout and bounded retry. Build option: NIC_CLK_MGR_RECOVER_EN.
module nic_clk_mgr
    import nic_clk_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_speed,
    output logic        req_ready,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        clk_ok,
    output logic [1:0]  cur_speed,
    output logic        busy,
    output logic        fail,
    output logic        lock_lost
);

    localparam int RST_CNT_W  = $clog2(RST_CYCLES + 1);
    localparam int LOCK_CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RETRY_W    = $clog2(MAX_RETRY + 1);

    mgr_state_t            state_reg, state_next;
    logic [RST_CNT_W-1:0]  rst_cnt_reg, rst_cnt_next;
    logic [LOCK_CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic [RETRY_W-1:0]    retry_reg, retry_next;
    logic [1:0]            target_reg, target_next;
    logic [1:0]            cur_speed_reg, cur_speed_next;
    logic                  clk_ok_reg, clk_ok_next;
    logic                  lock_lost_reg, lock_lost_next;
    logic [IDX_W-1:0]      entry_idx_reg, entry_idx_next;
    logic                  rmw_start_reg, rmw_start_next;
    logic                  lock_meta_reg, lock_sync_reg;

    logic       accept;
    logic       rmw_done;
    drp_entry_t tbl [TABLE_ENTRIES];
    drp_entry_t entry_sel;

    genvar gi;
    generate
        for (gi = 0; gi < TABLE_ENTRIES; gi++) begin : g_tbl
            assign tbl[gi] = table_entry(IDX_W'(gi), target_reg);
        end
    endgenerate

    assign entry_sel = tbl[entry_idx_reg];

    nic_clk_drp_rmw u_rmw (
        .clk       (clk),
        .srst      (reset),
        .start     (rmw_start_reg),
        .addr      (entry_sel.addr),
        .keep      (entry_sel.keep),
        .val       (entry_sel.val),
        .done      (rmw_done),
        .drp_daddr (drp_daddr),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RST;
            rst_cnt_reg   <= '0;
            lock_cnt_reg  <= '0;
            retry_reg     <= '0;
            target_reg    <= SPEED_1000M;
            cur_speed_reg <= SPEED_1000M;
            clk_ok_reg    <= 1'b0;
            lock_lost_reg <= 1'b0;
            entry_idx_reg <= '0;
            rmw_start_reg <= 1'b0;
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            lock_cnt_reg  <= lock_cnt_next;
            retry_reg     <= retry_next;
            target_reg    <= target_next;
            cur_speed_reg <= cur_speed_next;
            clk_ok_reg    <= clk_ok_next;
            lock_lost_reg <= lock_lost_next;
            entry_idx_reg <= entry_idx_next;
            rmw_start_reg <= rmw_start_next;
            lock_meta_reg <= mmcm_locked;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    assign req_ready = (state_reg == ST_RUN) || (state_reg == ST_FAIL);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next     = state_reg;
        rst_cnt_next   = rst_cnt_reg;
        lock_cnt_next  = lock_cnt_reg;
        retry_next     = retry_reg;
        target_next    = target_reg;
        cur_speed_next = cur_speed_reg;
        clk_ok_next    = clk_ok_reg;
        lock_lost_next = lock_lost_reg;
        entry_idx_next = entry_idx_reg;
        rmw_start_next = 1'b0;

        case (state_reg)
            ST_RST: begin
                if (rst_cnt_reg == RST_CNT_W'(RST_CYCLES - 1)) begin
                    rst_cnt_next   = '0;
                    entry_idx_next = '0;
                    rmw_start_next = 1'b1;
                    state_next     = ST_DRP;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            ST_DRP: begin
                if (rmw_done) begin
                    if (entry_idx_reg == IDX_W'(TABLE_ENTRIES - 1)) begin
                        lock_cnt_next = '0;
                        state_next    = ST_LOCK_W;
                    end else begin
                        entry_idx_next = entry_idx_reg + 1'b1;
                        rmw_start_next = 1'b1;
                    end
                end
            end
            ST_LOCK_W: begin
                if (lock_sync_reg) begin
                    clk_ok_next    = 1'b1;
                    cur_speed_next = target_reg;
                    retry_next     = '0;
                    state_next     = ST_RUN;
                end else if (lock_cnt_reg == LOCK_CNT_W'(LOCK_TIMEOUT)) begin
                    if (retry_reg == RETRY_W'(MAX_RETRY)) begin
                        state_next = ST_FAIL;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ST_RST;
                    end
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                clk_ok_next = lock_sync_reg;
                if (!lock_sync_reg) begin
                    lock_lost_next = 1'b1;
`ifdef NIC_CLK_MGR_RECOVER_EN
                    // automatic relock uses up a retry like a timeout would
                    if (retry_reg == RETRY_W'(MAX_RETRY)) begin
                        state_next = ST_FAIL;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ST_RST;
                    end
`else
                    state_next = ST_RUN;
`endif
                end
            end
            ST_FAIL: clk_ok_next = 1'b0;
            default: state_next = ST_RST;
        endcase

        // An accepted request always forces a full resequence, even at the same speed
        if (accept) begin
            target_next    = norm_speed(req_speed);
            lock_lost_next = 1'b0;
            retry_next     = '0;
            clk_ok_next    = 1'b0;
            rst_cnt_next   = '0;
            state_next     = ST_RST;
        end
    end

    assign mmcm_rst  = !((state_reg == ST_LOCK_W) || (state_reg == ST_RUN));
    assign busy      = !req_ready;
    assign fail      = (state_reg == ST_FAIL);
    assign clk_ok    = clk_ok_reg;
    assign cur_speed = cur_speed_reg;
    assign lock_lost = lock_lost_reg;

endmodule
